// File: rtl/run_sequencer.sv
// Host-side job sequencer for the 9-bit-instruction core: preloads data memory,
// kicks the core, waits for done (or a cycle limit), then drains a result window.
module run_sequencer #(
  parameter int AW         = 8,
  parameter int DW         = 8,
  parameter int MAX_CYCLES = 4096,
  parameter int CW         = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] wr_base,
  input  logic [AW:0]   wr_len,
  input  logic [AW-1:0] rd_base,
  input  logic [AW:0]   rd_len,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          mem_own,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wr_data,
  input  logic [DW-1:0] mem_rd_data,
  output logic          core_reset,
  output logic          core_req,
  input  logic          core_done,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic          busy,
  output logic          finished,
  output logic          timeout,
  output logic [CW-1:0] run_cycles
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CRST,
    S_RUN,
    S_DRAIN,
    S_FIN
  } state_e;

  localparam logic [31:0] RUN_LIMIT = 32'(MAX_CYCLES - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] wr_base_q, wr_base_d;
  logic [AW-1:0] rd_base_q, rd_base_d;
  logic [AW:0]   wr_len_q, wr_len_d;
  logic [AW:0]   rd_len_q, rd_len_d;
  logic [AW:0]   idx_q, idx_d;
  logic          timeout_q, timeout_d;
  logic [CW-1:0] run_cycles_q, run_cycles_d;

  logic [AW:0]   idx_inc;
  logic [CW-1:0] run_inc;
  logic          run_limit_hit;

  assign idx_inc       = idx_q + (AW+1)'(1);
  assign run_inc       = (run_cycles_q == '1) ? run_cycles_q : run_cycles_q + CW'(1);
  assign run_limit_hit = 32'(run_inc) >= RUN_LIMIT;

  assign timeout    = timeout_q;
  assign run_cycles = run_cycles_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      wr_base_q    <= '0;
      rd_base_q    <= '0;
      wr_len_q     <= '0;
      rd_len_q     <= '0;
      idx_q        <= '0;
      timeout_q    <= 1'b0;
      run_cycles_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_base_q    <= wr_base_d;
      rd_base_q    <= rd_base_d;
      wr_len_q     <= wr_len_d;
      rd_len_q     <= rd_len_d;
      idx_q        <= idx_d;
      timeout_q    <= timeout_d;
      run_cycles_q <= run_cycles_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    wr_base_d    = wr_base_q;
    rd_base_d    = rd_base_q;
    wr_len_d     = wr_len_q;
    rd_len_d     = rd_len_q;
    idx_d        = idx_q;
    timeout_d    = timeout_q;
    run_cycles_d = run_cycles_q;
    in_ready     = 1'b0;
    mem_own      = 1'b0;
    mem_wr_en    = 1'b0;
    mem_addr     = '0;
    mem_wr_data  = '0;
    core_reset   = 1'b0;
    core_req     = 1'b0;
    out_valid    = 1'b0;
    out_data     = '0;
    busy         = 1'b0;
    finished     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          wr_base_d    = wr_base;
          rd_base_d    = rd_base;
          wr_len_d     = wr_len;
          rd_len_d     = rd_len;
          idx_d        = '0;
          timeout_d    = 1'b0;
          run_cycles_d = '0;
          state_d      = (wr_len == '0) ? S_CRST : S_LOAD;
        end
      end

      S_LOAD: begin
        busy        = 1'b1;
        mem_own     = 1'b1;
        in_ready    = 1'b1;
        mem_addr    = wr_base_q + idx_q[AW-1:0];
        mem_wr_data = in_data;
        mem_wr_en   = in_valid;
        if (in_valid) begin
          idx_d = idx_inc;
          if (idx_inc == wr_len_q) state_d = S_CRST;
        end
      end

      S_CRST: begin
        busy       = 1'b1;
        core_reset = 1'b1;
        state_d    = S_RUN;
      end

      S_RUN: begin
        busy = 1'b1;
        // run_cycles is cleared at start, so zero marks the first RUN cycle.
        core_req     = (run_cycles_q == '0);
        run_cycles_d = run_inc;
        if (core_done) begin
          idx_d   = '0;
          state_d = (rd_len_q == '0) ? S_FIN : S_DRAIN;
        end else if (run_limit_hit) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end
      end

      S_DRAIN: begin
        busy      = 1'b1;
        mem_own   = 1'b1;
        mem_addr  = rd_base_q + idx_q[AW-1:0];
        out_valid = 1'b1;
        out_data  = mem_rd_data;
        if (out_ready) begin
          idx_d = idx_inc;
          if (idx_inc == rd_len_q) state_d = S_FIN;
        end
      end

      S_FIN: begin
        finished = 1'b1;
        state_d  = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_run_sequencer.sv
// Randomized scoreboard bench for run_sequencer: a job-level reference model
// predicts memory writes, result bytes, run_cycles and timeout for each job.
module tb_run_sequencer;
  localparam int AW   = 8;
  localparam int DW   = 8;
  localparam int MAXC = 16;
  localparam int CW   = 16;
  localparam int MEMN = 2 ** AW;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [AW-1:0] wr_base, rd_base;
  logic [AW:0]   wr_len, rd_len;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_data;
  logic          mem_own, mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data, mem_rd_data;
  logic          core_reset, core_req, core_done;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_data;
  logic          busy, finished, timeout;
  logic [CW-1:0] run_cycles;

  always #5 clk = ~clk;

  run_sequencer #(.AW(AW), .DW(DW), .MAX_CYCLES(MAXC), .CW(CW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .wr_base(wr_base), .wr_len(wr_len), .rd_base(rd_base), .rd_len(rd_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_own(mem_own), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
    .core_reset(core_reset), .core_req(core_req), .core_done(core_done),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .finished(finished), .timeout(timeout), .run_cycles(run_cycles)
  );

  // Environment: data memory and a core that raises done core_lat cycles
  // after req (1 = same cycle as req, 0 = never).
  logic [DW-1:0] mem [0:MEMN-1];
  assign mem_rd_data = mem[mem_addr];
  always @(posedge clk) if (mem_own && mem_wr_en) mem[mem_addr] <= mem_wr_data;

  int   core_lat = 1;
  int   core_cnt = 0;
  logic core_run = 1'b0;
  assign core_done = (core_req && core_lat == 1) ||
                     (core_run && core_lat > 1 && core_cnt == core_lat - 1);
  always @(posedge clk) begin
    if (reset || !busy) begin
      core_run <= 1'b0;
      core_cnt <= 0;
    end else if (core_done) begin
      core_run <= 1'b0;
    end else if (core_req) begin
      core_run <= 1'b1;
      core_cnt <= 1;
    end else if (core_run) begin
      core_cnt <= core_cnt + 1;
    end
  end

  // Reference model and scoreboard state.
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic [DW-1:0] ref_mem [0:MEMN-1];
  wr_t           exp_wr[$];
  logic [DW-1:0] exp_out[$];
  logic [DW-1:0] feed_q[$];
  logic [DW-1:0] fixed_q[$];
  int n_checks = 0, n_fail = 0;
  int crst_cnt = 0, req_cnt = 0, fin_cnt = 0, out_cnt = 0;
  int valid_mode = 0, ready_mode = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string msg);
    n_checks++;
    n_fail++;
    $display("FAIL %s", msg);
  endtask

  // Monitor: pops expectations whenever the DUT presents a write or a result byte.
  wr_t           mon_e;
  logic [DW-1:0] mon_o, stall_data;
  logic          stall_q = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      stall_q = 1'b0;
    end else begin
      if (mem_wr_en) begin
        check("wr_needs_in_valid", in_valid, 1'b1);
        check("wr_mem_own", mem_own, 1'b1);
        if (exp_wr.size() == 0) fail_now($sformatf("unexpected_write addr=0x%0h", mem_addr));
        else begin
          mon_e = exp_wr.pop_front();
          check("wr_addr", mem_addr, mon_e.addr);
          check("wr_data", mem_wr_data, mon_e.data);
        end
      end
      if (out_valid) begin
        check("drain_mem_own", mem_own, 1'b1);
        if (stall_q) check("out_stable", out_data, stall_data);
      end
      if (out_valid && out_ready) begin
        out_cnt++;
        if (exp_out.size() == 0) fail_now($sformatf("unexpected_out data=0x%0h", out_data));
        else begin
          mon_o = exp_out.pop_front();
          check("out_data", out_data, mon_o);
        end
      end
      stall_q    = out_valid && !out_ready;
      stall_data = out_data;
      if (core_reset) crst_cnt++;
      if (core_req) begin
        req_cnt++;
        check("req_mem_released", {mem_own, mem_wr_en}, 2'b00);
      end
      if (finished) begin
        fin_cnt++;
        check("fin_busy_low", busy, 1'b0);
      end
    end
  end

  // Host driver: presents preload bytes and result back-pressure each cycle.
  initial begin
    bit acc_in;
    bit tog;
    tog = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    forever begin
      @(negedge clk);
      acc_in = in_valid && in_ready && !reset;
      @(posedge clk); #1;
      if (acc_in && feed_q.size() > 0) void'(feed_q.pop_front());
      tog = ~tog;
      in_valid = (feed_q.size() > 0) &&
                 (valid_mode == 0 ? 1'b1 : valid_mode == 1 ? tog : 1'($urandom));
      in_data  = (feed_q.size() > 0) ? feed_q[0] : '0;
      out_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? tog : 1'($urandom);
    end
  end

  task automatic check_outputs_zero(input string name);
    check(name, {busy, in_ready, mem_own, mem_wr_en, core_reset, core_req, out_valid,
                 finished, timeout, mem_addr, mem_wr_data, out_data, run_cycles}, '0);
  endtask

  // Issues one job: the expected writes, result bytes and end status come from
  // the job-level rules, not from cycle behaviour.
  task automatic issue_job(input int wb, input int wl, input int rb, input int rl,
                           input int lat, input int vmode, input int rmode, input bit hold,
                           output bit exp_to, output int exp_rc);
    logic [DW-1:0] d;
    core_lat = lat; valid_mode = vmode; ready_mode = rmode;
    crst_cnt = 0; req_cnt = 0; fin_cnt = 0; out_cnt = 0;
    for (int i = 0; i < wl; i++) begin
      d = (fixed_q.size() > 0) ? fixed_q.pop_front() : DW'($urandom);
      feed_q.push_back(d);
      exp_wr.push_back('{addr: AW'(wb + i), data: d});
      ref_mem[(wb + i) % MEMN] = d;
    end
    exp_to = (lat == 0) || (lat > MAXC - 1);
    exp_rc = exp_to ? MAXC - 1 : lat;
    if (!exp_to) for (int j = 0; j < rl; j++) exp_out.push_back(ref_mem[(rb + j) % MEMN]);
    @(posedge clk); #1;
    start = 1'b1; wr_base = AW'(wb); wr_len = (AW+1)'(wl); rd_base = AW'(rb); rd_len = (AW+1)'(rl);
    @(posedge clk); #1;
    check("start_clears_status", {timeout, run_cycles}, '0);
    if (hold) begin
      wr_base = AW'($urandom); rd_base = AW'($urandom);
      wr_len = (AW+1)'($urandom_range(1, 9)); rd_len = (AW+1)'($urandom_range(1, 9));
      @(posedge clk); #1;
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic finish_job(input string tag, input bit exp_to, input int exp_rc);
    int budget;
    budget = 0;
    while (busy === 1'b1 && budget < 3000) begin
      @(posedge clk); #1;
      budget++;
    end
    if (budget >= 3000) fail_now({tag, " job_never_ended"});
    @(posedge clk); #1;
    check({tag, " busy_end"}, busy, 1'b0);
    check({tag, " core_reset_pulses"}, crst_cnt, 1);
    check({tag, " core_req_pulses"}, req_cnt, 1);
    check({tag, " finished_pulses"}, fin_cnt, exp_to ? 0 : 1);
    check({tag, " timeout"}, timeout, exp_to);
    check({tag, " run_cycles"}, run_cycles, exp_rc);
    check({tag, " writes_left"}, exp_wr.size(), 0);
    check({tag, " outputs_left"}, exp_out.size(), 0);
    exp_wr.delete(); exp_out.delete(); feed_q.delete();
  endtask

  task automatic job(input string tag, input int wb, input int wl, input int rb, input int rl,
                     input int lat, input int vmode, input int rmode, input bit hold);
    bit exp_to;
    int exp_rc;
    issue_job(wb, wl, rb, rl, lat, vmode, rmode, hold, exp_to, exp_rc);
    finish_job(tag, exp_to, exp_rc);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int  wb, wl, rb, rl, lat, budget;
    bit  exp_to;
    int  exp_rc;
    for (int i = 0; i < MEMN; i++) begin
      mem[i]     = DW'(i * 7) ^ DW'(8'h3C);
      ref_mem[i] = DW'(i * 7) ^ DW'(8'h3C);
    end
    reset = 1'b1; start = 1'b0;
    wr_base = '0; wr_len = '0; rd_base = '0; rd_len = '0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset_state");
    reset = 1'b0;

    fixed_q = '{8'd11, 8'd22, 8'd33, 8'd44};
    job("basic", 'h80, 4, 'h80, 4, 10, 0, 0, 1'b1);
    job("toggle", 'h30, 6, 'h30, 6, 5, 1, 1, 1'b0);
    job("wrap_rd0", 'hFE, 4, 'h10, 0, 7, 0, 2, 1'b0);
    job("timeout", 'h20, 3, 'h20, 3, 0, 0, 0, 1'b0);
    job("done_at_limit", 'h20, 3, 'h1F, 5, MAXC - 1, 2, 2, 1'b0);
    job("done_first", 'h00, 0, 'hFE, 4, 1, 0, 1, 1'b0);

    // Reset in the middle of a drain, then a clean job.
    issue_job('h40, 5, 'h40, 5, 3, 0, 0, 1'b0, exp_to, exp_rc);
    budget = 0;
    while (out_cnt < 2 && budget < 500) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 500) fail_now("drain_never_started");
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check_outputs_zero("mid_drain_reset");
    exp_wr.delete(); exp_out.delete(); feed_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    job("after_reset", 'h40, 5, 'h40, 5, 4, 2, 2, 1'b0);

    job("full_window", 'h55, MEMN, 'h55, MEMN, 2, 2, 2, 1'b0);

    for (int k = 0; k < 8; k++) begin
      wb  = $urandom_range(0, MEMN - 1);
      wl  = $urandom_range(0, 20);
      rb  = $urandom_range(0, MEMN - 1);
      rl  = $urandom_range(0, 20);
      lat = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, MAXC - 1);
      job($sformatf("rand%0d", k), wb, wl, rb, rl, lat, $urandom_range(0, 2),
          $urandom_range(0, 2), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/run_sequencer.md
Name: run_sequencer

Overview:
- Host-side sequencer in front of the 9-bit-instruction processor core.
- Preloads the core's data memory from a host byte stream, then resets the core and pulses its req.
- Waits for the core's done, then streams a result window of data memory back to the host.
- Owns the data-memory port while the core is idle; releases it while the core runs.

Parameters:
- AW, 8, data-memory address width
- DW, 8, data width
- MAX_CYCLES, 4096, run-cycle limit before timeout (power of two not required)
- CW, 16, width of cycle counter output

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- start  input  1  begin a job (sampled in IDLE only)
- wr_base  input  AW  first data-memory address for preload
- wr_len  input  AW+1  preload byte count (0..2^AW)
- rd_base  input  AW  first result address
- rd_len  input  AW+1  result byte count (0..2^AW)
- in_valid  input  1  host preload byte valid
- in_data  input  DW  host preload byte
- in_ready  output  1  sequencer accepts in_data
- mem_own  output  1  1 = sequencer drives data-memory port (muxed at top)
- mem_wr_en  output  1  data-memory write enable
- mem_addr  output  AW  data-memory address
- mem_wr_data  output  DW  data-memory write data
- mem_rd_data  input  DW  data-memory combinational read data
- core_reset  output  1  synchronous reset to core PC/flags
- core_req  output  1  start pulse to core
- core_done  input  1  core completion (combinational from PC)
- out_valid  output  1  result byte valid
- out_data  output  DW  result byte
- out_ready  input  1  host accepts result byte
- busy  output  1  job in progress
- finished  output  1  one-cycle pulse at successful job end
- timeout  output  1  sticky error; cleared by next accepted start
- run_cycles  output  CW  cycles spent in RUN for last job (saturating)

Behaviour:
- Reset: state IDLE; all outputs 0; latched bases/lengths, counters, timeout, run_cycles cleared.
- IDLE:
  - busy=0.
  - start=1 latches wr_base, wr_len, rd_base, rd_len; clears timeout and run_cycles; idx=0.
  - Next state is LOAD, or CRST if wr_len==0.
- LOAD:
  - busy=1, mem_own=1, in_ready=1.
  - mem_addr=(wr_base+idx) mod 2^AW (wrap), mem_wr_data=in_data.
  - mem_wr_en=in_valid, combinational; the write lands at the clock edge.
  - On accept, idx++; the accept with idx==wr_len-1 moves to CRST.
  - in_valid low: hold, no write.
- CRST: core_reset=1 for exactly one cycle; next RUN.
- RUN:
  - mem_own=0, mem_wr_en=0.
  - core_req=1 only in the first RUN cycle.
  - run_cycles increments each RUN cycle, saturating at 2^CW-1.
  - core_done=1 in any RUN cycle (first included): go DRAIN, idx=0, or go FIN if rd_len==0.
  - Otherwise, run_cycles reaching MAX_CYCLES-1 without done: set timeout, go IDLE, no finished pulse.
  - core_done and timeout limit in the same cycle: done wins.
- DRAIN:
  - mem_own=1, mem_wr_en=0.
  - mem_addr=(rd_base+idx) mod 2^AW; out_valid=1; out_data=mem_rd_data.
  - out_data stays stable while out_valid & !out_ready.
  - On out_valid&out_ready, idx++; the transfer with idx==rd_len-1 moves to FIN.
- FIN: finished=1 for one cycle, busy=0; next IDLE.
- start outside IDLE is ignored.
- in_ready=0 and out_valid=0 outside LOAD/DRAIN respectively.
- reset asserted mid-job (any state) returns to IDLE next edge with all outputs 0; no partial finished.
- run_cycles and timeout hold after job end until the next accepted start.
- Length counts are AW+1 bits so a full 2^AW window is legal.

Test Plan:
- Load 4 bytes {11,22,33,44} at wr_base=0x80, core raises done 10 cycles after req, rd_base=0x80 rd_len=4, out_ready=1 -> writes to 0x80..0x83, core_reset 1 cycle, core_req 1 cycle, run_cycles=10, outputs 11,22,33,44, finished pulse, busy low.
- in_valid toggling 1,0,1,0 and out_ready toggling during DRAIN -> no write on in_valid=0 cycles; out_data held stable while stalled; byte count exact.
- wr_base=0xFE, wr_len=4 -> writes 0xFE,0xFF,0x00,0x01; rd_len=0 -> FIN directly after done, no out_valid.
- MAX_CYCLES=16, core_done never asserts -> timeout=1 after 15 RUN cycles, no finished, IDLE; next start clears timeout.
- core_done already high in first RUN cycle, wr_len=0 -> IDLE, CRST, RUN (1 cycle, run_cycles=1), DRAIN.
- reset asserted during DRAIN after 2 of 5 bytes -> next cycle all outputs 0, state IDLE; new start runs cleanly.
